// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter fed by a small byte FIFO. Bytes pushed with wr_en are
// queued and sent as start + DATA_BITS (LSB first) + [parity] + stop bits.
// Frames queued back-to-back go out with no idle gap between them.
//
// Optional feature: define UART_TX_PARITY_EN to add the parity_en and
// parity_odd inputs and the PARITY bit slot.
//
// Ports:
//   clk         bus clock
//   rst_n       synchronous active-low reset (works regardless of clk_en)
//   clk_en      global clock enable; all state holds while low
//   wr_en       push wr_data into the FIFO
//   wr_data     byte to queue; bits [DATA_BITS-1:0] are transmitted
//   parity_en   (UART_TX_PARITY_EN only) insert a parity bit, sampled at pop
//   parity_odd  (UART_TX_PARITY_EN only) odd parity when high, sampled at pop
//   ovf_clr     clears the sticky overflow flag
//   tx          serial line, idle high, driven straight from a flop
//   full        FIFO full (registered)
//   empty       FIFO empty (registered)
//   count       FIFO occupancy
//   busy        high from the start bit to the end of the last stop bit
//   overflow    sticky, set when a write is dropped because the FIFO is full
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int BUS_CLK    = 10_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clk_en,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
`ifdef UART_TX_PARITY_EN
    input  logic                        parity_en,
    input  logic                        parity_odd,
`endif
    input  logic                        ovf_clr,
    output logic                        tx,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        busy,
    output logic                        overflow
);

    localparam int DIV      = BUS_CLK / BAUD;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CNT_W    = $clog2(STOP_LEN);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int BW       = $clog2(DATA_BITS);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    // Parameter sanity checks, evaluated at elaboration.
    if (DIV < 2) begin : gDivCheck
        $error("uart_tx_fifo: BUS_CLK/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : gDataBitsCheck
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : gStopBitsCheck
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gDepthCheck
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wrPtr_q, rdPtr_q;
    logic [AW:0]          count_q, count_d;
    logic                 full_q, empty_q, overflow_q;

    // Transmitter
    state_t               state_q;
    logic [CNT_W-1:0]     baudCnt_q;
    logic [BW-1:0]        bitIdx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q, busy_q;
`ifdef UART_TX_PARITY_EN
    logic                 parEn_q, parBit_q;
`endif

    logic                 push, pop, bitEnd, stopEnd;
    logic [DATA_BITS-1:0] head;

    assign head    = mem_q[rdPtr_q];
    assign bitEnd  = (baudCnt_q == CNT_W'(DIV - 1));
    assign stopEnd = (baudCnt_q == CNT_W'(STOP_LEN - 1));

    // A full FIFO refuses writes even if a pop frees a slot on the same edge.
    assign push = clk_en && wr_en && !full_q;
    // Pop either from idle or at the last stop cycle so the next start bit
    // follows the stop bit with no gap.
    assign pop  = clk_en && !empty_q &&
                  ((state_q == IDLE) || (state_q == STOP && stopEnd));

    // Occupancy next-state; a simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO data array; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= wr_data[DATA_BITS-1:0];
        end
    end

    // FIFO pointers and status flags. Pointers wrap naturally at the
    // power-of-two depth. A dropped write outranks ovf_clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else if (clk_en) begin
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
            if (wr_en && full_q) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Transmit FSM. Each state counts DIV enabled cycles per bit (STOP counts
    // STOP_BITS*DIV). A pop overrides whatever the case statement chose and
    // launches the start bit on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parEn_q   <= 1'b0;
            parBit_q  <= 1'b0;
`endif
        end else if (clk_en) begin
            unique case (state_q)
                START: begin
                    if (bitEnd) begin
                        baudCnt_q <= '0;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bitIdx_q  <= '0;
                        state_q   <= DATA;
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bitEnd) begin
                        baudCnt_q <= '0;
                        if (bitIdx_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            if (parEn_q) begin
                                tx_q    <= parBit_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            tx_q     <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                            bitIdx_q <= bitIdx_q + 1'b1;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bitEnd) begin
                        baudCnt_q <= '0;
                        tx_q      <= 1'b1;
                        state_q   <= STOP;
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (stopEnd) begin
                        baudCnt_q <= '0;
                        tx_q      <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (pop) begin
                state_q   <= START;
                baudCnt_q <= '0;
                shift_q   <= head;
                tx_q      <= 1'b0;
                busy_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                parEn_q   <= parity_en;
                parBit_q  <= (^head) ^ parity_odd;
`endif
            end
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Bench for uart_tx_fifo with BUS_CLK=1 MHz, BAUD=100 kHz (DIV=10),
// 8 data bits, 1 stop bit, 4-deep FIFO. Bytes are queued in a scoreboard as
// they are written; a line monitor decodes each frame off tx and compares
// it bit by bit against the oldest queued byte. Define UART_TX_PARITY_EN to
// also cover the parity bit.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int BUS_CLK    = 1_000_000;
    localparam int BAUD       = 100_000;
    localparam int DIV        = 10;
    localparam int FIFO_DEPTH = 4;

    logic       clk, rst_n, clk_en, wr_en, ovf_clr;
    logic [7:0] wr_data;
    logic       tx, full, empty, busy, overflow;
    logic [2:0] count;
`ifdef UART_TX_PARITY_EN
    logic       parity_en, parity_odd;
`endif

    typedef struct {
        logic [7:0] data;
        bit         hasPar;
        bit         parBit;
    } frame_t;

    typedef struct {
        logic       wrEn;
        logic [7:0] data;
        logic       ovfClr;
        bit         accept;
        logic [2:0] expCount;
        logic       expFull;
        logic       expEmpty;
        logic       expOvf;
    } vec_t;

    frame_t sbQ[$];
    vec_t   vecs[10];

    int checkCount = 0;
    int failCount  = 0;
    int bitCycles  = DIV;
    int busyCnt    = 0;
    int busyRises  = 0;
    int frameNo    = 0;
    bit abortMon   = 0;
    bit monActive  = 0;
    bit toggleEn   = 0;

    uart_tx_fifo #(
        .BUS_CLK    (BUS_CLK),
        .BAUD       (BAUD),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
`ifdef UART_TX_PARITY_EN
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
`endif
        .ovf_clr    (ovf_clr),
        .tx         (tx),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Toggles clk_en between clock edges when requested.
    initial begin : enableToggler
        forever begin
            @(posedge clk);
            #3;
            if (toggleEn) clk_en = ~clk_en;
        end
    end

    // Counts cycles with busy high and how many separate busy pulses occurred.
    initial begin : busyMeter
        logic busyPrev;
        busyPrev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                busyCnt++;
                if (!busyPrev) busyRises++;
            end
            busyPrev = (busy === 1'b1);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushFrame(input logic [7:0] d, input bit hp, input bit pb);
        frame_t f;
        f.data   = d;
        f.hasPar = hp;
        f.parBit = pb;
        sbQ.push_back(f);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        wr_en   = v.wrEn;
        wr_data = v.data;
        ovf_clr = v.ovfClr;
        if (v.wrEn && v.accept) pushFrame(v.data, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Holds wr_en for nCyc clock edges; the caller ensures only one is enabled.
    task automatic writeOne(input logic [7:0] d, input bit hp, input bit pb, input int nCyc);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        pushFrame(d, hp, pb);
        repeat (nCyc) @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n;
        n = 0;
        while (!(sbQ.size() == 0 && !monActive && busy === 1'b0 && empty === 1'b1)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_timeout"}, (n >= budget), 0);
    endtask

    // Line monitor: decodes each frame off tx and checks every bit holds the
    // expected level for bitCycles samples.
    initial begin : lineMonitor
        frame_t      f;
        logic [10:0] bits;
        int          nBits;
        bit          aborted, bad;
        logic        actual;
        forever begin
            @(negedge clk);
            if (!abortMon && tx === 1'b0) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_frame_tx", tx, 1);
                    while (tx === 1'b0 && !abortMon) @(negedge clk);
                end else begin
                    f = sbQ.pop_front();
                    monActive = 1'b1;
                    bits = '1;
                    bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) bits[i+1] = f.data[i];
                    nBits = 10;
                    if (f.hasPar) begin
                        bits[9] = f.parBit;
                        nBits = 11;
                    end
                    aborted = 1'b0;
                    for (int b = 0; b < nBits && !aborted; b++) begin
                        bad = 1'b0;
                        actual = tx;
                        for (int s = 0; s < bitCycles && !aborted; s++) begin
                            if (b != 0 || s != 0) @(negedge clk);
                            if (abortMon) begin
                                aborted = 1'b1;
                            end else if (!bad) begin
                                actual = tx;
                                if (tx !== bits[b]) bad = 1'b1;
                            end
                        end
                        if (!aborted)
                            checkOutput($sformatf("frame%0d_bit%0d", frameNo, b), actual, bits[b]);
                    end
                    monActive = 1'b0;
                    frameNo++;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        failCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

    initial begin : mainTest
        int lowCnt;
        clk_en  = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        ovf_clr = 1'b0;
        rst_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_en  = 1'b0;
        parity_odd = 1'b0;
`endif

        // FIFO fill/overflow vectors: only row1 overlaps with a pop.
        //            wr    data   clr  acc  cnt  full empty ovf
        vecs[0] = '{1'b1, 8'hA0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hA1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'hA2, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'hA3, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'hA4, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'hA5, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'hEE, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tx", tx, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single 0xA5 frame
        $display("[TB] single frame 0xA5");
        busyCnt = 0;
        busyRises = 0;
        writeOne(8'hA5, 1'b0, 1'b0, 1);
        waitIdle(400, "a5");
        checkOutput("a5_busy_cycles", busyCnt, 100);
        checkOutput("a5_busy_pulses", busyRises, 1);
        checkOutput("a5_tx_idle", tx, 1);

        // 0x00 then 0xFF on consecutive cycles: no gap between frames
        $display("[TB] back-to-back 0x00, 0xFF");
        busyCnt = 0;
        busyRises = 0;
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'h00;
        pushFrame(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        wr_data = 8'hFF;
        pushFrame(8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        wr_en = 1'b0;
        waitIdle(600, "b2b");
        checkOutput("b2b_busy_cycles", busyCnt, 200);
        checkOutput("b2b_busy_pulses", busyRises, 1);

        // Fill to full, overflow, clear priority
        $display("[TB] fifo fill and overflow vectors");
        busyCnt = 0;
        busyRises = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_count", i), count, vecs[i].expCount);
            checkOutput($sformatf("vec%0d_full", i), full, vecs[i].expFull);
            checkOutput($sformatf("vec%0d_empty", i), empty, vecs[i].expEmpty);
            checkOutput($sformatf("vec%0d_overflow", i), overflow, vecs[i].expOvf);
        end
        @(negedge clk);
        wr_en = 1'b0;
        ovf_clr = 1'b0;
        waitIdle(1500, "fill");
        checkOutput("fill_busy_cycles", busyCnt, 500);
        checkOutput("fill_busy_pulses", busyRises, 1);
        checkOutput("fill_count_end", count, 0);
        checkOutput("fill_full_end", full, 0);

        // clk_en toggling: every bit stretches to 20 clocks
        $display("[TB] clk_en toggling with 0x55");
        bitCycles = 2 * DIV;
        busyCnt = 0;
        busyRises = 0;
        toggleEn = 1'b1;
        writeOne(8'h55, 1'b0, 1'b0, 2);
        waitIdle(1000, "clken");
        toggleEn = 1'b0;
        checkOutput("clken_busy_cycles", busyCnt, 200);
        checkOutput("clken_busy_pulses", busyRises, 1);
        @(negedge clk);
        clk_en = 1'b1;
        bitCycles = DIV;

`ifdef UART_TX_PARITY_EN
        // Parity on 0x07 (three ones): even -> 1, odd -> 0
        $display("[TB] parity frames");
        parity_en = 1'b1;
        parity_odd = 1'b0;
        busyCnt = 0;
        writeOne(8'h07, 1'b1, 1'b1, 1);
        waitIdle(500, "par_even");
        checkOutput("par_even_busy_cycles", busyCnt, 110);
        parity_odd = 1'b1;
        busyCnt = 0;
        writeOne(8'h07, 1'b1, 1'b0, 1);
        waitIdle(500, "par_odd");
        checkOutput("par_odd_busy_cycles", busyCnt, 110);
        parity_en = 1'b0;
        parity_odd = 1'b0;
`endif

        // Reset in the middle of 0x3C's fourth data bit with 0x11 queued
        $display("[TB] reset mid-frame");
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'h3C;
        pushFrame(8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        wr_data = 8'h11;
        pushFrame(8'h11, 1'b0, 1'b0);
        @(negedge clk);
        wr_en = 1'b0;
        repeat (44) @(negedge clk);
        checkOutput("midrst_busy_before", busy, 1);
        checkOutput("midrst_count_before", count, 1);
        abortMon = 1'b1;
        clk_en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_tx", tx, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_count", count, 0);
        checkOutput("midrst_empty", empty, 1);
        @(negedge clk);
        rst_n = 1'b1;
        clk_en = 1'b1;
        sbQ.delete();
        @(negedge clk);
        abortMon = 1'b0;
        lowCnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1) lowCnt++;
        end
        checkOutput("midrst_no_frames", lowCnt, 0);
        checkOutput("midrst_busy_after", busy, 0);
        checkOutput("midrst_count_after", count, 0);

        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

endmodule
